time_syn_multi: RTL
===================

TIME_SYN_MULTI -- requirements
Module: time_syn_multi

Interface
REQ-001 P_PORT_NUM, 4, number of candidate upstream ports (1..8).
REQ-002 P_TS_WIDTH, 64, timestamp/local-time width.
REQ-003 P_FRAME_LEN, 8, cycles per timestamp frame send.
REQ-004 P_TIME_OUT, 300, wait-state timeout in cycles.
REQ-005 P_PROCESS, 4, fixed turnaround compensation in cycles.
REQ-006 P_AVG_LOG2, 2, log2 of delay rounds averaged per sync.
REQ-007 P_MAX_RETRY, 3, consecutive timeouts before failure.
REQ-008 i_clk  in  1  single clock.
REQ-009 i_rst  in  1  reset, synchronous, active-high.
REQ-010 i_master_mode  in  1  node is the standard-time source.
REQ-011 i_time_syn_start  in  1  start request, rising-edge detected.
REQ-012 i_port_sel  in  $clog2(P_PORT_NUM) (min 1)  upstream port to sync against.
REQ-013 i_resync_period  in  32  idle cycles between periodic syncs; 0 = one-shot.
REQ-014 i_recv_return_valid  in  P_PORT_NUM  per-port returned-timestamp strobe.
REQ-015 i_recv_return_ts  in  P_PORT_NUM*P_TS_WIDTH  per-port returned timestamp, port 0 in LSBs.
REQ-016 i_recv_std_valid  in  P_PORT_NUM  per-port standard-time strobe.
REQ-017 i_recv_std_time  in  P_PORT_NUM*P_TS_WIDTH  per-port standard time.
REQ-018 o_send_ts_valid  out  P_PORT_NUM  one-hot request to the port's framer to send o_local_time.
REQ-019 o_local_time  out  P_TS_WIDTH  local time.
REQ-020 o_time_offset  out  P_TS_WIDTH  averaged one-way delay.
REQ-021 o_busy / o_syn_done / o_syn_fail  out  1 each  status levels.

Function
REQ-022 o_local_time SHALL increment by 1 every cycle, wrapping modulo 2^P_TS_WIDTH, except in the CORRECT load.
REQ-023 When i_master_mode=1 the FSM SHALL stay in IDLE and ignore all rx strobes; o_syn_done SHALL be 0.
REQ-024 States: IDLE, SEND_TS, WAIT_RET, WAIT_STD, CORRECT, DONE, FAIL.
REQ-025 IDLE->SEND_TS on a start edge with i_master_mode=0; i_port_sel SHALL be latched then, and changes mid-sync ignored.
REQ-026 SEND_TS SHALL last P_FRAME_LEN+1 cycles with o_send_ts_valid bit [sel] high, registered (one cycle after state entry), then go to WAIT_RET.
REQ-027 In WAIT_RET, i_recv_return_valid[sel] SHALL capture delay = (o_local_time - ret_ts - P_PROCESS) >> 1, modulo 2^P_TS_WIDTH, added into a P_TS_WIDTH+P_AVG_LOG2 accumulator.
REQ-028 After round 2^P_AVG_LOG2 the FSM SHALL enter WAIT_STD, registering o_time_offset = accumulator >> P_AVG_LOG2; otherwise return to SEND_TS.
REQ-029 In WAIT_STD, i_recv_std_valid[sel] SHALL go to CORRECT, where o_local_time loads std_time + o_time_offset + 2.
REQ-030 CORRECT->DONE in one cycle; o_syn_done SHALL set, the retry counter clear.
REQ-031 DONE SHALL count i_resync_period cycles then go to SEND_TS (accumulator and round count cleared); with period 0 it SHALL hold until the next start edge.
REQ-032 WAIT_RET or WAIT_STD reaching P_TIME_OUT cycles SHALL increment the retry count, clear accumulator/rounds and go to SEND_TS; reaching P_MAX_RETRY SHALL go to FAIL with o_syn_fail=1 and o_syn_done=0.
REQ-033 FAIL SHALL hold until a start edge, which clears fail and retries and enters SEND_TS.
REQ-034 Strobes on non-selected ports, and strobes in non-waiting states, SHALL be ignored; a return and std strobe in the same cycle SHALL be handled per current state only.
REQ-035 A start edge while busy SHALL be ignored; o_busy=1 in SEND_TS, WAIT_RET, WAIT_STD and CORRECT.

Reset
REQ-036 On i_rst: FSM IDLE; local time, offset, accumulator and counters 0; all outputs 0.
REQ-037 Reset mid-sync SHALL abort with no partial offset kept.

Structure
REQ-038 State encodings and the +2 correction constant SHALL reside in package time_syn_pkg.
REQ-039 A sub-module time_syn_delay_avg (accumulate/shift averager) SHALL be instantiated; the port mux SHALL be inline.

Verification
REQ-040 P_AVG_LOG2=2, returns giving delays 10,12,10,12 -> o_time_offset=11 entering WAIT_STD; std_time=1000 -> o_local_time=1013 the next cycle.
REQ-041 No return on the selected port -> retries at 300-cycle timeouts; after 3 timeouts o_syn_fail=1; start edge -> SEND_TS.
REQ-042 i_port_sel=2, strobes on port 1 only -> ignored, timeout; strobes on port 2 -> completes.
REQ-043 i_resync_period=50 -> SEND_TS re-entered exactly 50 cycles after DONE entry; o_syn_done stays 1.
REQ-044 o_local_time at 2^64-2 -> wraps to 0 two cycles later; a delay computed across the wrap is correct modulo 2^64.
REQ-045 i_master_mode=1 with rx strobes -> time free-runs, FSM stays IDLE; i_rst in WAIT_RET -> all outputs 0.

Source files
------------

// File: rtl/time_syn_pkg.sv
// Shared definitions for the multi-port time synchronisation block.
package time_syn_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SEND_TS  = 3'd1,
      ST_WAIT_RET = 3'd2,
      ST_WAIT_STD = 3'd3,
      ST_CORRECT  = 3'd4,
      ST_DONE     = 3'd5,
      ST_FAIL     = 3'd6
   } state_t;

   // Cycles between capturing standard time and the corrected value appearing.
   localparam int unsigned CORR_ADJ = 2;

   function automatic logic is_busy_state(input state_t st);
      logic busy;
      case (st)
         ST_SEND_TS, ST_WAIT_RET, ST_WAIT_STD, ST_CORRECT: busy = 1'b1;
         default:                                          busy = 1'b0;
      endcase
      return busy;
   endfunction

endpackage

// File: rtl/time_syn_delay_avg.sv
// Delay averager: accumulates per-round delays and exposes the running
// sum (including the current input) divided by 2^P_AVG_LOG2.
module time_syn_delay_avg #(
   parameter int P_TS_WIDTH = 64,
   parameter int P_AVG_LOG2 = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clr,
   input  logic                  i_add,
   input  logic [P_TS_WIDTH-1:0] i_delay,
   output logic [P_TS_WIDTH-1:0] o_avg_next
);

   localparam int ACC_W = P_TS_WIDTH + P_AVG_LOG2;

   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] sum_s;

   assign sum_s      = acc_r + ACC_W'(i_delay);
   assign o_avg_next = P_TS_WIDTH'(sum_s >> P_AVG_LOG2);

   // accumulator register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc_r <= '0;
      end else if (i_clr) begin
         acc_r <= '0;
      end else if (i_add) begin
         acc_r <= sum_s;
      end
   end

endmodule

// File: rtl/time_syn_multi.sv
// Slave-side time synchronisation against one selectable upstream port:
// averages the one-way delay over several exchanges, then loads standard time.
module time_syn_multi
   import time_syn_pkg::*;
#(
   parameter int P_PORT_NUM  = 4,
   parameter int P_TS_WIDTH  = 64,
   parameter int P_FRAME_LEN = 8,
   parameter int P_TIME_OUT  = 300,
   parameter int P_PROCESS   = 4,
   parameter int P_AVG_LOG2  = 2,
   parameter int P_MAX_RETRY = 3
) (
   input  logic                                                 i_clk,
   input  logic                                                 i_rst,
   input  logic                                                 i_master_mode,
   input  logic                                                 i_time_syn_start,
   input  logic [((P_PORT_NUM > 1) ? $clog2(P_PORT_NUM) : 1)-1:0] i_port_sel,
   input  logic [31:0]                                          i_resync_period,
   input  logic [P_PORT_NUM-1:0]                                i_recv_return_valid,
   input  logic [P_PORT_NUM*P_TS_WIDTH-1:0]                     i_recv_return_ts,
   input  logic [P_PORT_NUM-1:0]                                i_recv_std_valid,
   input  logic [P_PORT_NUM*P_TS_WIDTH-1:0]                     i_recv_std_time,
   output logic [P_PORT_NUM-1:0]                                o_send_ts_valid,
   output logic [P_TS_WIDTH-1:0]                                o_local_time,
   output logic [P_TS_WIDTH-1:0]                                o_time_offset,
   output logic                                                 o_busy,
   output logic                                                 o_syn_done,
   output logic                                                 o_syn_fail
);

   localparam int                    SEL_W      = (P_PORT_NUM > 1) ? $clog2(P_PORT_NUM) : 1;
   localparam int                    RND_W      = P_AVG_LOG2 + 1;
   localparam logic [RND_W-1:0]      LAST_RND   = RND_W'((1 << P_AVG_LOG2) - 1);
   localparam logic [31:0]           FRAME_LAST = 32'(P_FRAME_LEN);
   localparam logic [31:0]           TO_LAST    = 32'(P_TIME_OUT - 1);
   localparam logic [7:0]            RETRY_MAX  = 8'(P_MAX_RETRY);
   localparam logic [P_TS_WIDTH-1:0] PROC_C     = P_TS_WIDTH'(P_PROCESS);
   localparam logic [P_TS_WIDTH-1:0] ADJ_C      = P_TS_WIDTH'(CORR_ADJ);
   localparam logic [P_PORT_NUM-1:0] ONE_HOT0   = P_PORT_NUM'(1);

   state_t                  state_r, state_s;
   logic                    start_d_r, start_edge_s;
   logic [SEL_W-1:0]        sel_r;
   logic [31:0]             cnt_r;
   logic [RND_W-1:0]        rounds_r;
   logic [7:0]              retry_r;
   logic [P_TS_WIDTH-1:0]   local_time_r, offset_r, std_hold_r;
   logic [P_PORT_NUM-1:0]   send_valid_r;
   logic                    busy_r, done_r, fail_r;

   logic                    ret_vld_s, std_vld_s;
   logic [P_TS_WIDTH-1:0]   ret_ts_s, std_ts_s, delay_s, avg_next_s;
   logic                    clr_s, add_s, cap_off_s, retry_inc_s, retry_clr_s, latch_sel_s;

   assign start_edge_s = i_time_syn_start & ~start_d_r;

   // selected-port receive mux
   always_comb begin
      ret_vld_s = 1'b0;
      std_vld_s = 1'b0;
      ret_ts_s  = '0;
      std_ts_s  = '0;
      for (int p = 0; p < P_PORT_NUM; p++) begin
         ret_vld_s = ret_vld_s | ((sel_r == SEL_W'(p)) & i_recv_return_valid[p]);
         std_vld_s = std_vld_s | ((sel_r == SEL_W'(p)) & i_recv_std_valid[p]);
         ret_ts_s  = (sel_r == SEL_W'(p)) ? i_recv_return_ts[p*P_TS_WIDTH +: P_TS_WIDTH] : ret_ts_s;
         std_ts_s  = (sel_r == SEL_W'(p)) ? i_recv_std_time[p*P_TS_WIDTH +: P_TS_WIDTH] : std_ts_s;
      end
   end

   // Half the round trip minus the far end's fixed turnaround, wrapping naturally.
   assign delay_s = (local_time_r - ret_ts_s - PROC_C) >> 1;

   time_syn_delay_avg #(
      .P_TS_WIDTH (P_TS_WIDTH),
      .P_AVG_LOG2 (P_AVG_LOG2)
   ) u_delay_avg (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clr      (clr_s),
      .i_add      (add_s),
      .i_delay    (delay_s),
      .o_avg_next (avg_next_s)
   );

   // next-state and control strobes
   always_comb begin
      state_s     = state_r;
      clr_s       = 1'b0;
      add_s       = 1'b0;
      cap_off_s   = 1'b0;
      retry_inc_s = 1'b0;
      retry_clr_s = 1'b0;
      latch_sel_s = 1'b0;
      if (i_master_mode) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_edge_s) begin
                  state_s     = ST_SEND_TS;
                  latch_sel_s = 1'b1;
                  clr_s       = 1'b1;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_SEND_TS: begin
               if (cnt_r == FRAME_LAST) begin
                  state_s = ST_WAIT_RET;
               end else begin
                  state_s = ST_SEND_TS;
               end
            end
            ST_WAIT_RET, ST_WAIT_STD: begin
               if (state_r == ST_WAIT_RET && ret_vld_s) begin
                  add_s = 1'b1;
                  if (rounds_r == LAST_RND) begin
                     state_s   = ST_WAIT_STD;
                     cap_off_s = 1'b1;
                  end else begin
                     state_s = ST_SEND_TS;
                  end
               end else if (state_r == ST_WAIT_STD && std_vld_s) begin
                  state_s = ST_CORRECT;
               end else if (cnt_r == TO_LAST) begin
                  retry_inc_s = 1'b1;
                  clr_s       = 1'b1;
                  state_s     = ((retry_r + 8'd1) >= RETRY_MAX) ? ST_FAIL : ST_SEND_TS;
               end else begin
                  state_s = state_r;
               end
            end
            ST_CORRECT: begin
               state_s     = ST_DONE;
               retry_clr_s = 1'b1;
            end
            ST_DONE: begin
               if (start_edge_s) begin
                  state_s     = ST_SEND_TS;
                  latch_sel_s = 1'b1;
                  clr_s       = 1'b1;
               end else if (i_resync_period != 32'd0 && cnt_r == (i_resync_period - 32'd1)) begin
                  state_s = ST_SEND_TS;
                  clr_s   = 1'b1;
               end else begin
                  state_s = ST_DONE;
               end
            end
            ST_FAIL: begin
               if (start_edge_s) begin
                  state_s     = ST_SEND_TS;
                  latch_sel_s = 1'b1;
                  clr_s       = 1'b1;
                  retry_clr_s = 1'b1;
               end else begin
                  state_s = ST_FAIL;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // state, counters and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r      <= ST_IDLE;
         start_d_r    <= 1'b0;
         sel_r        <= '0;
         cnt_r        <= 32'd0;
         rounds_r     <= '0;
         retry_r      <= 8'd0;
         local_time_r <= '0;
         offset_r     <= '0;
         std_hold_r   <= '0;
         send_valid_r <= '0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         fail_r       <= 1'b0;
      end else begin
         state_r   <= state_s;
         start_d_r <= i_time_syn_start;
         cnt_r     <= (state_s != state_r) ? 32'd0 : cnt_r + 32'd1;
         if (latch_sel_s) begin
            sel_r <= i_port_sel;
         end
         if (clr_s) begin
            rounds_r <= '0;
         end else if (add_s) begin
            rounds_r <= rounds_r + RND_W'(1);
         end
         if (retry_clr_s) begin
            retry_r <= 8'd0;
         end else if (retry_inc_s) begin
            retry_r <= retry_r + 8'd1;
         end
         if (state_r == ST_CORRECT) begin
            local_time_r <= std_hold_r + offset_r + ADJ_C;
         end else begin
            local_time_r <= local_time_r + P_TS_WIDTH'(1);
         end
         if (state_s == ST_CORRECT) begin
            std_hold_r <= std_ts_s;
         end
         if (cap_off_s) begin
            offset_r <= avg_next_s;
         end
         send_valid_r <= (state_r == ST_SEND_TS) ? (ONE_HOT0 << sel_r) : '0;
         busy_r       <= is_busy_state(state_s);
         fail_r       <= (state_s == ST_FAIL);
         if (state_s == ST_FAIL || state_s == ST_IDLE) begin
            done_r <= 1'b0;
         end else if (state_r == ST_CORRECT) begin
            done_r <= 1'b1;
         end
      end
   end

   assign o_send_ts_valid = send_valid_r;
   assign o_local_time    = local_time_r;
   assign o_time_offset   = offset_r;
   assign o_busy          = busy_r;
   assign o_syn_done      = done_r;
   assign o_syn_fail      = fail_r;

endmodule
